// File: rtl/spi_pkg.sv
// Shared SPI types and mode helpers used by the SPI master and slave.
package spi_pkg;

    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slave_state_t;

    function automatic logic cpol(input spi_mode_t m);
        return m[1];
    endfunction

    function automatic logic cpha(input spi_mode_t m);
        return m[0];
    endfunction

endpackage

// File: rtl/spi_slave_if.sv
// Bus-side and user-side signals of the SPI slave, grouped for port passing.
interface spi_slave_if;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic [1:0] mode;
    logic [7:0] tx_data;
    logic       tx_load;
    logic       tx_ready;
    logic       miso;
    logic       miso_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       tx_underrun;
    logic       busy;

    modport slave (
        input  sclk, cs_n, mosi, mode, tx_data, tx_load,
        output tx_ready, miso, miso_oe, rx_data, rx_valid, tx_underrun, busy
    );

    modport master (
        output sclk, cs_n, mosi, mode, tx_data, tx_load,
        input  tx_ready, miso, miso_oe, rx_data, rx_valid, tx_underrun, busy
    );
endinterface

// File: rtl/spi_sync.sv
// 1-bit multi-flop synchronizer; reset value is a constant or taken from a port.
module spi_sync #(
    parameter int SYNC_STAGES     = 2,
    parameter bit RESET_VAL       = 1'b0,
    parameter bit RESET_FROM_PORT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    input  logic i_rst_val,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_rst_val;

    assign w_rst_val = RESET_FROM_PORT ? i_rst_val : RESET_VAL;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_STAGES{w_rst_val}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, one-deep TX holding buffer.
module spi_slave
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] DEFAULT_TX  = 8'hFF
) (
    input logic        clk,
    input logic        rst,
    spi_slave_if.slave bus
);

    logic w_sclk_s, w_cs_s, w_mosi_s;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RESET_FROM_PORT(1'b1)) u_sync_sclk (
        .clk(clk), .rst(rst), .i_async(bus.sclk), .i_rst_val(bus.mode[1]), .o_sync(w_sclk_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1), .RESET_FROM_PORT(1'b0)) u_sync_cs (
        .clk(clk), .rst(rst), .i_async(bus.cs_n), .i_rst_val(1'b0), .o_sync(w_cs_s)
    );
    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0), .RESET_FROM_PORT(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .i_async(bus.mosi), .i_rst_val(1'b0), .o_sync(w_mosi_s)
    );

    logic r_sclk_prev, r_cs_prev;
    logic r_sclk_rise, r_sclk_fall, r_cs_fall, r_cs_rise;

    // Registered edge flags add the one cycle beyond the synchronizer depth.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sclk_prev <= bus.mode[1];
            r_cs_prev   <= 1'b1;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_cs_prev   <= w_cs_s;
            r_sclk_rise <= w_sclk_s & ~r_sclk_prev;
            r_sclk_fall <= ~w_sclk_s & r_sclk_prev;
            r_cs_fall   <= ~w_cs_s & r_cs_prev;
            r_cs_rise   <= w_cs_s & ~r_cs_prev;
        end
    end

    spi_slave_state_t r_state;
    spi_mode_t        r_mode;
    logic [2:0]       r_bit_cnt;
    logic [7:0]       r_shift_in, r_shift_out, r_rx_data, r_tx_buf;
    logic             r_tx_full, r_rx_valid, r_underrun;

    logic       w_sample, w_shift, w_consume;
    logic [7:0] w_next_tx;

    assign w_sample  = (cpol(r_mode) ^ cpha(r_mode)) ? r_sclk_fall : r_sclk_rise;
    assign w_shift   = (cpol(r_mode) ^ cpha(r_mode)) ? r_sclk_rise : r_sclk_fall;
    assign w_consume = ((r_state == IDLE) && r_cs_fall) ||
                       ((r_state == ACTIVE) && !r_cs_rise && w_sample && (r_bit_cnt == 3'd7));
    assign w_next_tx = r_tx_full ? r_tx_buf : DEFAULT_TX;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode      <= MODE0;
            r_bit_cnt   <= '0;
            r_shift_in  <= '0;
            r_shift_out <= '0;
            r_rx_data   <= '0;
            r_tx_buf    <= '0;
            r_tx_full   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            r_underrun <= w_consume && !r_tx_full;

            if (w_consume) begin
                r_shift_out <= w_next_tx;
                r_tx_full   <= 1'b0;
            end
            // A load on an empty buffer wins over a same-cycle consumption.
            if (bus.tx_load && !r_tx_full) begin
                r_tx_buf  <= bus.tx_data;
                r_tx_full <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (r_cs_fall) begin
                        r_mode    <= spi_mode_t'(bus.mode);
                        r_bit_cnt <= '0;
                        r_state   <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (r_cs_rise) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                    end else if (w_sample) begin
                        r_shift_in <= {r_shift_in[6:0], w_mosi_s};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data  <= {r_shift_in[6:0], w_mosi_s};
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_shift && (r_bit_cnt != 3'd0)) begin
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (r_state == ACTIVE);
    assign bus.miso_oe     = (r_state == ACTIVE);
    assign bus.miso        = (r_state == ACTIVE) & r_shift_out[7];
    assign bus.tx_ready    = ~r_tx_full;
    assign bus.rx_data     = r_rx_data;
    assign bus.rx_valid    = r_rx_valid;
    assign bus.tx_underrun = r_underrun;

endmodule
